// File: rtl/iic_req_arbiter.sv
// iic_req_arbiter: round-robin arbiter that shares one iic_cm I2C master
// between NREQ requesters. Each grant runs one 24-bit write: latch the word,
// hold iic_tr_go for GO_HOLD cycles, wait for a rising edge on iic_tr_done,
// then pulse ack for the granted requester.
// Optional feature macro: IIC_ARB_TIMEOUT_EN adds a done-wait timeout that
// ends the transfer with an err pulse instead of ack.

module iic_req_arbiter #(
    parameter int          NREQ        = 4,
    parameter logic [15:0] GO_HOLD     = 16'd512,
    parameter logic [23:0] TOUT_CYCLES = 24'd5_000_000
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [24*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic [23:0]          iic_data,
    output logic                 iic_tr_go,
    input  logic                 iic_tr_done
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [15:0]        hold_cnt;
    logic               done_q;
    logic               done_rise;

    logic [23:0]        words [NREQ];
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   win_idx;
    logic               win_any;

`ifdef IIC_ARB_TIMEOUT_EN
    logic [23:0]        tout_cnt;
`endif

    // Slice the flat request bus into one word per requester.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign words[g] = req_data[24*g +: 24];
    end

    assign done_rise = iic_tr_done & ~done_q;
    assign busy      = (state != IDLE);

    // Round-robin winner: first set request scanning rr_ptr+1, rr_ptr+2, ...
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is
        // inferred; blocking assignments are correct in combinational logic.
        win_idx = rr_ptr;
        win_any = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NREQ);
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant/transfer sequencer with registered outputs.
    always_ff @(posedge clk_50m) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= PTR_W'(NREQ - 1);
            hold_cnt  <= '0;
            done_q    <= 1'b0;
            gnt       <= '0;
            ack       <= '0;
            iic_data  <= '0;
            iic_tr_go <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
            err       <= '0;
            tout_cnt  <= '0;
`endif
        end else begin
            // done_q always tracks the input, so a done that rose during GO
            // produces no edge once WAIT is entered.
            done_q <= iic_tr_done;
            ack    <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
            err    <= '0;
`endif
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state     <= GO;
                        gnt       <= NREQ'(1) << win_idx;
                        iic_data  <= words[win_idx];
                        rr_ptr    <= win_idx;
                        iic_tr_go <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GO: begin
                    if (hold_cnt == GO_HOLD - 16'd1) begin
                        iic_tr_go <= 1'b0;
                        state     <= WAIT;
`ifdef IIC_ARB_TIMEOUT_EN
                        tout_cnt  <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                WAIT: begin
                    // gnt is one-hot of the winner, so it doubles as the
                    // ack/err select and is cleared on the same edge.
                    if (done_rise) begin
                        state <= FIN;
                        ack   <= gnt;
                        gnt   <= '0;
                    end
`ifdef IIC_ARB_TIMEOUT_EN
                    else if (tout_cnt == TOUT_CYCLES - 24'd1) begin
                        state <= FIN;
                        err   <= gnt;
                        gnt   <= '0;
                    end else begin
                        tout_cnt <= tout_cnt + 24'd1;
                    end
`endif
                end
                FIN: begin
                    // ack/err is visible in this cycle; the next IDLE cycle
                    // re-arbitrates, so the earliest new grant is 2 cycles on.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef IIC_ARB_TIMEOUT_EN
    assign err = '0;
`endif

endmodule
